// File: rtl/layer_sequencer.sv
// Descriptor-driven stage scheduler: fetches 46-bit descriptors from a synchronous
// table and hands each stage to the pointwise or depthwise controller in turn.
module layer_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              desc_rd_en,
  output logic [ADDR_W-1:0] desc_addr,
  input  logic [45:0]       desc_data,
  output logic [9:0]        W_start_address,
  output logic [3:0]        filter_channel_max,
  output logic [5:0]        filter_number_max,
  output logic [13:0]       window_size_max,
  output logic [1:0]        padding,
  output logic [6:0]        row_size,
  output logic              activation_function_enable,
  output logic              Point_Enabel,
  input  logic              Point_End,
  output logic              Depth_Enable,
  input  logic              Depth_End,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] stage_idx
);

  // IDLE wait start | FETCH read strobe | WAIT decode | ISSUE enable pulse | RUN wait end | DONE pulse
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0]    PTR_LAST  = '1;
  localparam logic [ADDR_W-1:0]    PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_ONE    = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_EXPIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]     stage_idx_q, stage_idx_d;
  logic [ADDR_W-1:0]     desc_addr_q, desc_addr_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic                  depth_q, depth_d;
  logic [43:0]           cfg_q, cfg_d;
  logic                  rd_en_q, rd_en_d;
  logic                  pen_q, pen_d;
  logic                  den_q, den_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  end_match;

  assign end_match = depth_q ? Depth_End : Point_End;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    stage_idx_d = stage_idx_q;
    desc_addr_d = desc_addr_q;
    wd_d        = wd_q;
    depth_d     = depth_q;
    cfg_d       = cfg_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = start_addr;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        case (desc_data[45:44])
          2'b11: state_d = S_DONE;
          2'b10: begin
            cfg_d   = desc_data[43:0];
            error_d = 1'b1;
            state_d = S_IDLE;
          end
          default: begin
            cfg_d   = desc_data[43:0];
            depth_d = desc_data[44];
            state_d = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A matching end takes priority over watchdog expiry in the same cycle.
        if (end_match) begin
          if (ptr_q == PTR_LAST) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + PTR_ONE;
            state_d = S_FETCH;
          end
        end else if (wd_q == WD_EXPIRE) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with that state.
    rd_en_d = (state_d == S_FETCH);
    if (state_d == S_FETCH) begin
      desc_addr_d = ptr_d;
      stage_idx_d = ptr_d;
    end
    pen_d  = (state_d == S_ISSUE) && !depth_d;
    den_d  = (state_d == S_ISSUE) && depth_d;
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      stage_idx_q <= '0;
      desc_addr_q <= '0;
      wd_q        <= '0;
      depth_q     <= 1'b0;
      cfg_q       <= '0;
      rd_en_q     <= 1'b0;
      pen_q       <= 1'b0;
      den_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      stage_idx_q <= stage_idx_d;
      desc_addr_q <= desc_addr_d;
      wd_q        <= wd_d;
      depth_q     <= depth_d;
      cfg_q       <= cfg_d;
      rd_en_q     <= rd_en_d;
      pen_q       <= pen_d;
      den_q       <= den_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign desc_rd_en                 = rd_en_q;
  assign desc_addr                  = desc_addr_q;
  assign stage_idx                  = stage_idx_q;
  assign activation_function_enable = cfg_q[43];
  assign W_start_address            = cfg_q[42:33];
  assign filter_channel_max         = cfg_q[32:29];
  assign filter_number_max          = cfg_q[28:23];
  assign window_size_max            = cfg_q[22:9];
  assign padding                    = cfg_q[8:7];
  assign row_size                   = cfg_q[6:0];
  assign Point_Enabel               = pen_q;
  assign Depth_Enable               = den_q;
  assign busy                       = busy_q;
  assign done                       = done_q;
  assign error                      = error_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: scenario table over a 4-entry descriptor
// table, plus directed sequences for end-pulse filtering, watchdog, busy-start and reset.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  start_addr;
  logic        desc_rd_en;
  logic [1:0]  desc_addr;
  logic [45:0] desc_data = '0;
  logic [9:0]  W_start_address;
  logic [3:0]  filter_channel_max;
  logic [5:0]  filter_number_max;
  logic [13:0] window_size_max;
  logic [1:0]  padding;
  logic [6:0]  row_size;
  logic        activation_function_enable;
  logic        Point_Enabel, Point_End, Depth_Enable, Depth_End;
  logic        busy, done, error;
  logic [1:0]  stage_idx;

  layer_sequencer #(.ADDR_W(2), .TIMEOUT_W(6)) dut (
    .clk(clk), .rst(rst_n), .start(start), .start_addr(start_addr),
    .desc_rd_en(desc_rd_en), .desc_addr(desc_addr), .desc_data(desc_data),
    .W_start_address(W_start_address), .filter_channel_max(filter_channel_max),
    .filter_number_max(filter_number_max), .window_size_max(window_size_max),
    .padding(padding), .row_size(row_size),
    .activation_function_enable(activation_function_enable),
    .Point_Enabel(Point_Enabel), .Point_End(Point_End),
    .Depth_Enable(Depth_Enable), .Depth_End(Depth_End),
    .busy(busy), .done(done), .error(error), .stage_idx(stage_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous descriptor table: data valid the cycle after the read strobe.
  logic [45:0] rom [4];
  always @(posedge clk) if (desc_rd_en) desc_data <= rom[desc_addr];

  // Controller responder: end pulse resp_lat cycles after the enable (0 = never).
  int   resp_lat = 0;
  int   pc = 0, dc = 0;
  logic point_resp = 1'b0, depth_resp = 1'b0;
  logic man_point = 1'b0, spur_depth = 1'b0;
  always @(posedge clk) begin
    point_resp <= 1'b0;
    depth_resp <= 1'b0;
    if (Point_Enabel && resp_lat > 0) begin
      if (resp_lat == 1) point_resp <= 1'b1; else pc <= resp_lat - 1;
    end else if (pc > 0) begin
      pc <= pc - 1;
      if (pc == 1) point_resp <= 1'b1;
    end
    if (Depth_Enable && resp_lat > 0) begin
      if (resp_lat == 1) depth_resp <= 1'b1; else dc <= resp_lat - 1;
    end else if (dc > 0) begin
      dc <= dc - 1;
      if (dc == 1) depth_resp <= 1'b1;
    end
  end
  assign Point_End = point_resp | man_point;
  assign Depth_End = depth_resp | spur_depth;

  logic [43:0] cfg_now;
  logic [53:0] all_outs;
  assign cfg_now  = {activation_function_enable, W_start_address, filter_channel_max,
                     filter_number_max, window_size_max, padding, row_size};
  assign all_outs = {busy, done, error, desc_rd_en, desc_addr, stage_idx,
                     Point_Enabel, Depth_Enable, cfg_now};

  // Event monitor, sampled mid-cycle.
  int          en_n = 0, p_cnt = 0, d_cnt = 0, done_cnt = 0, rd_cnt = 0;
  int          done_cyc = 0, pe_cyc = 0;
  logic [63:0] ord_log = '0;
  logic [43:0] cfg_log [64];
  logic [1:0]  idx_log [64];
  int          en_cyc  [64];
  always @(negedge clk) begin
    if ((Point_Enabel || Depth_Enable) && en_n < 63) begin
      ord_log[en_n] = Depth_Enable;
      cfg_log[en_n] = cfg_now;
      idx_log[en_n] = stage_idx;
      en_cyc[en_n]  = cyc;
      en_n++;
    end
    if (Point_Enabel) p_cnt++;
    if (Depth_Enable) d_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (desc_rd_en) rd_cnt++;
    if (Point_End) pe_cyc = cyc;
  end

  int n_vec = 0, n_err = 0;
  int start_cyc = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] a);
    start_addr = a;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, k);
    end
  endtask

  function automatic logic [45:0] mk(input logic [1:0] t, input logic act, input logic [9:0] w,
                                     input logic [3:0] ch, input logic [5:0] fn,
                                     input logic [13:0] win, input logic [1:0] pad,
                                     input logic [6:0] row);
    return {t, act, w, ch, fn, win, pad, row};
  endfunction

  typedef struct {
    logic [3:0][45:0] ent;
    logic [1:0]       saddr;
    int               lat;
    int               exp_p, exp_d, exp_done;
    logic             exp_err;
    logic [1:0]       exp_idx;
    logic [2:0]       exp_order;
  } scen_t;

  scen_t sc [5];

  initial begin
    logic [45:0] p0, p2, d1, e, ill;
    int pb, db, nb, rb, eb;

    p0  = mk(2'b00, 1'b1, 10'd0,   4'd1,  6'd1,  14'd3136,  2'd0, 7'd56);
    p2  = mk(2'b00, 1'b0, 10'd300, 4'd15, 6'd63, 14'd100,   2'd2, 7'd10);
    d1  = mk(2'b01, 1'b0, 10'd64,  4'd3,  6'd7,  14'd12544, 2'd1, 7'd112);
    e   = {2'b11, 44'h5A5A5A5A5A5};
    ill = {2'b10, 44'h0F0F0F0F0F0};

    sc[0].ent = {e, e, e, p0};     sc[0].saddr = 2'd0; sc[0].lat = 20;
    sc[0].exp_p = 1; sc[0].exp_d = 0; sc[0].exp_done = 1; sc[0].exp_err = 1'b0;
    sc[0].exp_idx = 2'd1; sc[0].exp_order = 3'b000;
    sc[1].ent = {e, p2, d1, p0};   sc[1].saddr = 2'd0; sc[1].lat = 5;
    sc[1].exp_p = 2; sc[1].exp_d = 1; sc[1].exp_done = 1; sc[1].exp_err = 1'b0;
    sc[1].exp_idx = 2'd3; sc[1].exp_order = 3'b010;
    sc[2].ent = {e, p0, ill, p2};  sc[2].saddr = 2'd0; sc[2].lat = 4;
    sc[2].exp_p = 1; sc[2].exp_d = 0; sc[2].exp_done = 0; sc[2].exp_err = 1'b1;
    sc[2].exp_idx = 2'd1; sc[2].exp_order = 3'b000;
    sc[3].ent = {p2, e, e, d1};    sc[3].saddr = 2'd3; sc[3].lat = 3;
    sc[3].exp_p = 1; sc[3].exp_d = 0; sc[3].exp_done = 1; sc[3].exp_err = 1'b0;
    sc[3].exp_idx = 2'd3; sc[3].exp_order = 3'b000;
    sc[4].ent = {e, e, d1, e};     sc[4].saddr = 2'd1; sc[4].lat = 1;
    sc[4].exp_p = 0; sc[4].exp_d = 1; sc[4].exp_done = 1; sc[4].exp_err = 1'b0;
    sc[4].exp_idx = 2'd2; sc[4].exp_order = 3'b001;

    rst_n = 1'b0; start = 1'b0; start_addr = 2'd0;
    for (int k = 0; k < 4; k++) rom[k] = e;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outs), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(all_outs), 64'd0);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) rom[k] = sc[i].ent[k];
      resp_lat = sc[i].lat;
      pb = p_cnt; db = d_cnt; nb = done_cnt; eb = en_n;
      do_start(sc[i].saddr);
      wait_idle($sformatf("s%0d_idle", i));
      repeat (2) @(negedge clk);
      check($sformatf("s%0d_point_pulses", i), 64'(p_cnt - pb), 64'(sc[i].exp_p));
      check($sformatf("s%0d_depth_pulses", i), 64'(d_cnt - db), 64'(sc[i].exp_d));
      check($sformatf("s%0d_done_pulses", i), 64'(done_cnt - nb), 64'(sc[i].exp_done));
      check($sformatf("s%0d_error", i), 64'(error), 64'(sc[i].exp_err));
      check($sformatf("s%0d_stage_idx", i), 64'(stage_idx), 64'(sc[i].exp_idx));
      check($sformatf("s%0d_order", i), 64'(ord_log[eb +: 3]), 64'(sc[i].exp_order));
      check($sformatf("s%0d_first_cfg", i), 64'(cfg_log[eb]), 64'(sc[i].ent[sc[i].saddr][43:0]));
      if (i == 0) begin
        check("s0_enable_latency", 64'(en_cyc[eb] - start_cyc), 64'd3);
        check("s0_window_act", 64'({activation_function_enable, window_size_max}),
              64'({1'b1, 14'd3136}));
        check("s0_done_after_end", 64'(done_cyc - pe_cyc), 64'd3);
        check("s0_cfg_held_after_eol", 64'(cfg_now), 64'(p0[43:0]));
      end
      if (i == 1) begin
        check("s1_depth_cfg", 64'({cfg_log[eb+1][22:9], cfg_log[eb+1][8:7], cfg_log[eb+1][6:0]}),
              64'({14'd12544, 2'd1, 7'd112}));
        check("s1_idx_steps", 64'({idx_log[eb], idx_log[eb+1], idx_log[eb+2]}),
              64'({2'd0, 2'd1, 2'd2}));
      end
    end

    // End pulse in ISSUE and spurious depth end during a pointwise stage are ignored.
    rom[0] = p0; rom[1] = e; resp_lat = 0;
    pb = p_cnt; rb = rd_cnt; nb = done_cnt;
    do_start(2'd0);
    @(negedge clk);
    @(negedge clk);
    check("issue_pulse_present", 64'(Point_Enabel), 64'd1);
    man_point = 1'b1;
    @(negedge clk);
    man_point  = 1'b0;
    spur_depth = 1'b1;
    @(negedge clk);
    spur_depth = 1'b0;
    repeat (5) @(negedge clk);
    check("ignored_ends_busy", 64'({busy, stage_idx}), 64'({1'b1, 2'd0}));
    check("ignored_ends_no_fetch", 64'(rd_cnt - rb), 64'd1);
    man_point = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    man_point = 1'b0;
    wait_idle("manual_end_idle");
    check("manual_end_done_latency", 64'(done_cyc - start_cyc), 64'd3);
    check("manual_end_points", 64'(p_cnt - pb), 64'd1);
    check("manual_end_dones", 64'(done_cnt - nb), 64'd1);

    // Watchdog: 63 RUN cycles without an end.
    @(negedge clk);
    nb = done_cnt;
    do_start(2'd0);
    repeat (65) @(negedge clk);
    check("wdog_before_limit", 64'({error, busy}), 64'({1'b0, 1'b1}));
    @(negedge clk);
    check("wdog_expired", 64'({error, busy}), 64'({1'b1, 1'b0}));
    check("wdog_no_done", 64'(done_cnt - nb), 64'd0);
    resp_lat = 2;
    @(negedge clk);
    do_start(2'd0);
    check("start_clears_error", 64'({error, busy}), 64'({1'b0, 1'b1}));
    wait_idle("after_wdog_idle");
    check("after_wdog_done", 64'({error, 32'(done_cnt - nb)}), 64'({1'b0, 32'd1}));

    // start while busy is ignored.
    rom[0] = p0; rom[1] = e; rom[2] = d1; rom[3] = e;
    resp_lat = 10;
    pb = p_cnt; db = d_cnt; nb = done_cnt;
    @(negedge clk);
    do_start(2'd0);
    repeat (4) @(negedge clk);
    start_addr = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start_idle");
    check("busy_start_counts", 64'({32'(p_cnt - pb), 32'(d_cnt - db)}), 64'({32'd1, 32'd0}));
    check("busy_start_idx", 64'(stage_idx), 64'd1);
    check("busy_start_done", 64'(done_cnt - nb), 64'd1);

    // Reset mid-RUN, then a late end pulse.
    resp_lat = 0;
    @(negedge clk);
    do_start(2'd0);
    repeat (5) @(negedge clk);
    check("pre_reset_running", 64'({busy, cfg_now}), 64'({1'b1, p0[43:0]}));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_mid_run", 64'(all_outs), 64'd0);
    pb = p_cnt; rb = rd_cnt;
    @(negedge clk);
    man_point = 1'b1;
    @(negedge clk);
    man_point = 1'b0;
    repeat (4) @(negedge clk);
    check("late_end_ignored", 64'(all_outs), 64'd0);
    check("late_end_no_activity", 64'({32'(p_cnt - pb), 32'(rd_cnt - rb)}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
